wr_seq_gen: RTL
===============

# wr_seq_gen

Write-sequence generator that drives the `en`/`d` write side of a downstream enable-gated register. It is the producer end of that interface: on a `start` request it emits a programmed burst of `count` write strobes. Data begins at `base` and advances by `stride`, with `gap` idle cycles between writes. It sits in front of register targets in equivalence and miter benches, and in datapath blocks that need paced register loads.

## Interface
- `WIDTH`, 32, data width of `d`, `base`, `stride`
- `CNT_W`, 16, width of the write-count field
- `GAP_W`, 8, width of the inter-write gap field

- `clk` in 1, single clock, rising edge
- `rst_n` in 1, reset, asynchronous and active-low
- `start` in 1, begin a burst; sampled only in IDLE
- `base` in WIDTH, first data value; latched on accepted `start`
- `stride` in WIDTH, per-write data increment; latched on accepted `start`
- `count` in CNT_W, number of writes; latched on accepted `start`
- `gap` in GAP_W, idle cycles between consecutive writes; latched on accepted `start`
- `hold` in 1, stall request from the downstream side
- `en` out 1, write strobe to the downstream register
- `d` out WIDTH, write data; valid when `en`=1
- `busy` out 1, high from the cycle after an accepted `start` through the DONE cycle
- `done` out 1, single-cycle pulse at the end of each burst

## Operation
- All outputs are registered. Reset values: `en`=0, `d`=0, `busy`=0, `done`=0, FSM=IDLE, internal counters 0.
- FSM states are IDLE, WRITE, GAP and DONE.
- **IDLE:**
  - `start`=1 latches `base`/`stride`/`count`/`gap`, sets `cur`=`base` and `rem`=`count`.
  - If `count`=0, go to DONE with no writes; otherwise go to WRITE.
- **WRITE:**
  - If `hold`=1: `en`=0, no state change, no counter advance.
  - Otherwise: `en`=1, `d`=`cur`, `cur`←`cur`+`stride` (mod 2^WIDTH, wraps silently), `rem`←`rem`−1.
  - Next state on the last write (`rem`=1): DONE.
  - Next state on other writes: GAP with `gcnt`=`gap` if `gap`≠0; stay in WRITE if `gap`=0.
- **GAP:**
  - `en`=0 and `gcnt` decrements each cycle.
  - Move to WRITE when `gcnt` reaches 1.
  - `hold` has no effect in GAP.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored while `busy`=1; there is no queueing.
- `start` is accepted in the cycle the FSM re-enters IDLE. Back-to-back bursts therefore have a minimum of one IDLE cycle between DONE and the next first write.
- `d` holds its last written value while `en`=0.
- Asserting `rst_n` low mid-burst aborts immediately. Outputs go to reset values asynchronously and no `done` is emitted.

## Timing
- `start` accepted at edge t gives first `en`=1 at t+1.
- Consecutive writes (no `hold`) are spaced `gap`+1 cycles apart.
- `done` is high in the cycle after the last `en`.
- A burst with `count`=N and no `hold` occupies N + (N−1)·`gap` + 1 busy cycles. The +1 is the DONE cycle.
- `count`=0 gives `busy` and `done` both high for one cycle at t+1.
- Each `hold` cycle during WRITE extends the burst by exactly one cycle.

## Configuration
- Macro: `WR_SEQ_CHECK_EN`.
- **Defined:**
  - Adds input `q` (WIDTH, downstream register readback), output `mismatch` (1, reset 0) and an internal shadow register (reset 0).
  - The shadow register loads `d` on every `en`=1 cycle.
  - `mismatch` is sticky. It sets when `q`≠shadow in any cycle after the first write of a burst.
  - `mismatch` clears on an accepted `start` or on reset.
- **Undefined:** no `q` port, no `mismatch` port, no shadow logic. Write behaviour is identical to the defined case.

## Test plan
- Reset, then `start` with `base`=0x10, `stride`=4, `count`=3, `gap`=0 → `en` high for 3 consecutive cycles with `d`=0x10, 0x14, 0x18, then `done` pulse the next cycle.
- `count`=2, `gap`=2, `base`=0xA, `stride`=1 → writes of 0xA and 0xB separated by two `en`=0 cycles; `busy` high for 5 cycles.
- `base`=0xFFFFFFFE, `stride`=1, `count`=3 → `d`=0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap).
- `count`=4, `gap`=0, `hold`=1 for 2 cycles after the second write → exactly 4 writes; `done` delayed 2 cycles; a `start` pulse mid-burst is ignored.
- `count`=0 → no `en`; `busy` and `done` high for one cycle. Separately, drop `rst_n` mid-burst → `en`/`busy`/`done`/`d` read 0 immediately, with no `done` afterward.
- With `WR_SEQ_CHECK_EN`: tie `q` to a correct one-cycle-delayed register model → `mismatch` stays 0. Force `q`=0xDEAD after a write of 0x14 → `mismatch`=1 and it stays 1 until the next `start`.

Source files
------------

// File: rtl/wr_seq_gen.sv
// wr_seq_gen: write-sequence generator for an enable-gated downstream register.
// On an accepted start it emits `count` write strobes. Data starts at `base`
// and steps by `stride`, with `gap` idle cycles between writes. `hold` stalls
// the next write slot.
// Optional readback checker: define WR_SEQ_CHECK_EN to add i_q / o_mismatch.
//
// The state register holds the phase of the cycle currently visible on the
// outputs. All outputs are registered alongside it. A "write slot" is decided
// at the edge that enters a WRITE cycle, so hold is sampled at that edge.
module wr_seq_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16,
    parameter int GAP_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_base,
    input  logic [WIDTH-1:0] i_stride,
    input  logic [CNT_W-1:0] i_count,
    input  logic [GAP_W-1:0] i_gap,
    input  logic             i_hold,
`ifdef WR_SEQ_CHECK_EN
    input  logic [WIDTH-1:0] i_q,
    output logic             o_mismatch,
`endif
    output logic             o_en,
    output logic [WIDTH-1:0] o_d,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_en, w_en_nxt;
    logic [WIDTH-1:0] r_d, w_d_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [WIDTH-1:0] r_cur, w_cur_nxt;
    logic [WIDTH-1:0] r_stride, w_stride_nxt;
    logic [CNT_W-1:0] r_rem, w_rem_nxt;
    logic [GAP_W-1:0] r_gap, w_gap_nxt;
    logic [GAP_W-1:0] r_gcnt, w_gcnt_nxt;

    // Write-slot request and its operands. In IDLE the operands come straight
    // from the inputs, so the first write lands in the first busy cycle.
    logic             w_slot;
    logic [WIDTH-1:0] w_slot_cur;
    logic [WIDTH-1:0] w_slot_stride;
    logic [CNT_W-1:0] w_slot_rem;

    // State and output registers; reset aborts any burst with no done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_en     <= 1'b0;
            r_d      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cur    <= '0;
            r_stride <= '0;
            r_rem    <= '0;
            r_gap    <= '0;
            r_gcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_en     <= w_en_nxt;
            r_d      <= w_d_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_cur    <= w_cur_nxt;
            r_stride <= w_stride_nxt;
            r_rem    <= w_rem_nxt;
            r_gap    <= w_gap_nxt;
            r_gcnt   <= w_gcnt_nxt;
        end
    end

    // Next-state and next-output logic; r_rem counts writes still to issue
    always_comb begin
        w_state_nxt   = r_state;
        w_en_nxt      = 1'b0;
        w_d_nxt       = r_d;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_cur_nxt     = r_cur;
        w_stride_nxt  = r_stride;
        w_rem_nxt     = r_rem;
        w_gap_nxt     = r_gap;
        w_gcnt_nxt    = r_gcnt;
        w_slot        = 1'b0;
        w_slot_cur    = r_cur;
        w_slot_stride = r_stride;
        w_slot_rem    = r_rem;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (i_start) begin
                    w_busy_nxt   = 1'b1;
                    w_stride_nxt = i_stride;
                    w_gap_nxt    = i_gap;
                    w_cur_nxt    = i_base;
                    w_rem_nxt    = i_count;
                    if (i_count == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_slot        = 1'b1;
                        w_slot_cur    = i_base;
                        w_slot_stride = i_stride;
                        w_slot_rem    = i_count;
                    end
                end
            end
            S_WRITE: begin
                // r_en low here means the slot was held; retry it
                if (!r_en) begin
                    w_slot = 1'b1;
                end else if (r_rem == '0) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else if (r_gap != '0) begin
                    w_state_nxt = S_GAP;
                    w_gcnt_nxt  = r_gap;
                end else begin
                    w_slot = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gcnt == GAP_W'(1)) w_slot = 1'b1;
                else                     w_gcnt_nxt = r_gcnt - GAP_W'(1);
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_slot) begin
            w_state_nxt = S_WRITE;
            if (!i_hold) begin
                w_en_nxt  = 1'b1;
                w_d_nxt   = w_slot_cur;
                w_cur_nxt = w_slot_cur + w_slot_stride;
                w_rem_nxt = w_slot_rem - CNT_W'(1);
            end
        end
    end

    assign o_en   = r_en;
    assign o_d    = r_d;
    assign o_busy = r_busy;
    assign o_done = r_done;

`ifdef WR_SEQ_CHECK_EN
    logic [WIDTH-1:0] r_shadow;
    logic             r_armed;
    logic             r_mismatch;
    logic             w_start_acc;

    assign w_start_acc = (r_state == S_IDLE) && i_start;

    // Shadow follows what the downstream register should hold. Compare once a
    // write has landed in the current burst; the flag is sticky until start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow   <= '0;
            r_armed    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            if (r_en) r_shadow <= r_d;
            if (w_start_acc) begin
                r_armed    <= 1'b0;
                r_mismatch <= 1'b0;
            end else begin
                if (r_en) r_armed <= 1'b1;
                if (r_armed && (i_q != r_shadow)) r_mismatch <= 1'b1;
            end
        end
    end

    assign o_mismatch = r_mismatch;
`endif

endmodule
